onchip_mem_arbiter: RTL and testbench

- Two-master round-robin arbiter that shares one single-port on-chip RAM (32-bit data, 14-bit word address, 1-cycle read latency) between two processor cores.
- It presents two pipelined Avalon-MM slave ports with waitrequest and readdatavalid.
- It drives the RAM's address, byteenable, chipselect, write, writedata and clken inputs, and returns its readdata.
- It sits between the core data masters and the shared image-buffer RAM.

---
 rtl/onchip_mem_arbiter_if.sv | 22 ++
 rtl/onchip_mem_arbiter.sv | 76 +++++++
 tb/tb_onchip_mem_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/onchip_mem_arbiter_if.sv
// onchip_mem_arbiter_if: one pipelined Avalon-MM port with waitrequest and readdatavalid.
interface onchip_mem_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );
  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: two-master round-robin arbiter sharing one single-port RAM with 1-cycle read latency.
// Defining ONCHIP_MEM_ARB_STATS_EN adds saturating grant and contention counters.
module onchip_mem_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                reset,
  onchip_mem_arbiter_if.slave m0,
  onchip_mem_arbiter_if.slave m1,
`ifdef ONCHIP_MEM_ARB_STATS_EN
  input  logic                stat_clear,
  output logic [31:0]         stat_m0_grants,
  output logic [31:0]         stat_m1_grants,
  output logic [31:0]         stat_contention,
`endif
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);
  logic       req0, req1, acc, win, win_wr, owner, tag_v, tag_m;
  logic [3:0] hold_cnt;
  always_comb begin
    req0   = m0.read | m0.write;
    req1   = m1.read | m1.write;
    acc    = (req0 | req1) & ~reset;
    win    = (req0 & req1) ? ((hold_cnt < 4'(MAX_HOLD)) ? owner : ~owner) : req1;
    win_wr = win ? m1.write : m0.write;
  end
  assign m0.waitrequest   = ~(acc & ~win);
  assign m1.waitrequest   = ~(acc & win);
  assign m0.readdata      = mem_readdata;
  assign m1.readdata      = mem_readdata;
  assign m0.readdatavalid = tag_v & ~tag_m & ~reset;
  assign m1.readdatavalid = tag_v & tag_m & ~reset;
  assign mem_chipselect   = acc;
  assign mem_write        = acc & win_wr;
  assign mem_address      = win ? m1.address : m0.address;
  assign mem_byteenable   = win ? m1.byteenable : m0.byteenable;
  assign mem_writedata    = win ? m1.writedata : m0.writedata;
  assign mem_clken        = ~reset;
  // a simultaneous read+write is a write, so only pure reads get a return tag
  always_ff @(posedge clk)
    if (reset) begin
      owner    <= 1'b0;
      hold_cnt <= '0;
      tag_v    <= 1'b0;
      tag_m    <= 1'b0;
    end else begin
      tag_v <= acc & ~win_wr;
      tag_m <= win;
      if (!acc) hold_cnt <= '0;
      else if (win == owner) hold_cnt <= hold_cnt + {3'd0, hold_cnt != 4'hf};
      else begin
        owner    <= win;
        hold_cnt <= 4'd1;
      end
    end
`ifdef ONCHIP_MEM_ARB_STATS_EN
  always_ff @(posedge clk)
    if (reset | stat_clear) begin
      stat_m0_grants  <= '0;
      stat_m1_grants  <= '0;
      stat_contention <= '0;
    end else begin
      if (acc & ~win & ~&stat_m0_grants) stat_m0_grants <= stat_m0_grants + 32'd1;
      if (acc & win & ~&stat_m1_grants) stat_m1_grants <= stat_m1_grants + 32'd1;
      if (req0 & req1 & ~&stat_contention) stat_contention <= stat_contention + 32'd1;
    end
`endif
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb_onchip_mem_arbiter: scoreboard bench with a RAM fixture and a spec-level arbitration/memory model.
module tb_onchip_mem_arbiter;
  localparam int MAX_HOLD = 4;
  typedef struct {int m; logic [31:0] d; int due;} rd_t;
  logic clk, reset, mem_chipselect, mem_write, mem_clken;
  logic [13:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata, mem_readdata;
  logic [31:0] ram [0:16383];
  logic [31:0] mdl [0:16383];
  int tests, fails, cyc, last, run, ew, first_acc, last_acc;
  bit r0, r1, w;
  logic [13:0] a;
  logic [31:0] d;
  logic [3:0] be;
  rd_t rq[$];
  rd_t e;
  int glog[$];
  onchip_mem_arbiter_if #(.ADDR_W(14), .DATA_W(32)) m0_bus();
  onchip_mem_arbiter_if #(.ADDR_W(14), .DATA_W(32)) m1_bus();
`ifdef ONCHIP_MEM_ARB_STATS_EN
  logic stat_clear;
  logic [31:0] stat_m0_grants, stat_m1_grants, stat_contention;
  int eg0, eg1, ec;
`endif
  onchip_mem_arbiter #(.ADDR_W(14), .DATA_W(32), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(reset), .m0(m0_bus), .m1(m1_bus),
`ifdef ONCHIP_MEM_ARB_STATS_EN
    .stat_clear(stat_clear), .stat_m0_grants(stat_m0_grants),
    .stat_m1_grants(stat_m1_grants), .stat_contention(stat_contention),
`endif
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // RAM fixture: single-port, byte-lane writes, registered read
  always @(posedge clk)
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int i = 0; i < 4; i++)
          if (mem_byteenable[i]) ram[mem_address][8*i +: 8] <= mem_writedata[8*i +: 8];
      end else mem_readdata <= ram[mem_address];
    end
  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // monitor + reference model: spec-level arbitration and a flat memory array
  always @(negedge clk) begin
    cyc++;
    r0 = m0_bus.read | m0_bus.write;
    r1 = m1_bus.read | m1_bus.write;
    if (reset) begin
      chk(m0_bus.waitrequest && m1_bus.waitrequest, "rst_wait", {m1_bus.waitrequest, m0_bus.waitrequest}, 2'b11);
      chk(!mem_chipselect && !mem_write && !mem_clken, "rst_mem", {mem_chipselect, mem_write, mem_clken}, 3'b000);
      chk(!m0_bus.readdatavalid && !m1_bus.readdatavalid, "rst_rdv", {m1_bus.readdatavalid, m0_bus.readdatavalid}, 2'b00);
      rq.delete();
      last = 0;
      run = 0;
`ifdef ONCHIP_MEM_ARB_STATS_EN
      eg0 = 0; eg1 = 0; ec = 0;
`endif
    end else begin
      chk(mem_clken == 1'b1, "clken", mem_clken, 1);
      if (rq.size() > 0 && rq[0].due == cyc) begin
        e = rq.pop_front();
        chk({m1_bus.readdatavalid, m0_bus.readdatavalid} == 2'(1 << e.m), "rdv_steer",
            {m1_bus.readdatavalid, m0_bus.readdatavalid}, 2'(1 << e.m));
        chk((e.m ? m1_bus.readdata : m0_bus.readdata) == e.d, "rdata", e.m ? m1_bus.readdata : m0_bus.readdata, e.d);
      end else
        chk(!m0_bus.readdatavalid && !m1_bus.readdatavalid, "rdv_idle", {m1_bus.readdatavalid, m0_bus.readdatavalid}, 2'b00);
      ew = (r0 && r1) ? ((run < MAX_HOLD) ? last : 1 - last) : r1 ? 1 : r0 ? 0 : -1;
      chk({~m1_bus.waitrequest, ~m0_bus.waitrequest} == ((ew < 0) ? 2'b00 : 2'(1 << ew)), "grant",
          {~m1_bus.waitrequest, ~m0_bus.waitrequest}, (ew < 0) ? 2'b00 : 2'(1 << ew));
      chk(mem_chipselect == (ew >= 0), "cs", mem_chipselect, ew >= 0);
`ifdef ONCHIP_MEM_ARB_STATS_EN
      if (stat_clear) begin
        eg0 = 0; eg1 = 0; ec = 0;
      end else begin
        if (ew == 0) eg0++;
        if (ew == 1) eg1++;
        if (r0 && r1) ec++;
      end
`endif
      if (ew < 0) run = 0;
      else begin
        w  = ew ? m1_bus.write : m0_bus.write;
        a  = ew ? m1_bus.address : m0_bus.address;
        d  = ew ? m1_bus.writedata : m0_bus.writedata;
        be = ew ? m1_bus.byteenable : m0_bus.byteenable;
        chk(mem_write == w, "mem_write", mem_write, w);
        chk(mem_address == a, "mem_addr", mem_address, a);
        if (w) begin
          chk(mem_writedata == d && mem_byteenable == be, "mem_wdata", {mem_byteenable, mem_writedata}, {be, d});
          for (int i = 0; i < 4; i++) if (be[i]) mdl[a][8*i +: 8] = d[8*i +: 8];
        end else rq.push_back('{m: ew, d: mdl[a], due: cyc + 1});
        run = (ew == last) ? ((run < 15) ? run + 1 : 15) : 1;
        last = ew;
        glog.push_back(ew);
        if (glog.size() == 1) first_acc = cyc;
        last_acc = cyc;
      end
    end
  end
  task automatic xfer(input int m, input bit wr, input logic [13:0] ad, input logic [31:0] wd, input logic [3:0] b);
    bit wt;
    if (m == 0) begin
      m0_bus.address = ad; m0_bus.write = wr; m0_bus.read = !wr; m0_bus.writedata = wd; m0_bus.byteenable = b;
    end else begin
      m1_bus.address = ad; m1_bus.write = wr; m1_bus.read = !wr; m1_bus.writedata = wd; m1_bus.byteenable = b;
    end
    for (int t = 0; ; t++) begin
      @(negedge clk) wt = (m == 0) ? m0_bus.waitrequest : m1_bus.waitrequest;
      @(posedge clk);
      if (!wt) break;
      if (t > 100) begin
        chk(0, "accept_timeout", m, 0);
        break;
      end
    end
    #1;
    if (m == 0) begin m0_bus.read = 0; m0_bus.write = 0; end
    else begin m1_bus.read = 0; m1_bus.write = 0; end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 16384; i++) begin ram[i] = '0; mdl[i] = '0; end
    {m0_bus.read, m0_bus.write, m1_bus.read, m1_bus.write} = '0;
    {m0_bus.address, m1_bus.address, m0_bus.writedata, m1_bus.writedata} = '0;
    m0_bus.byteenable = 4'hf; m1_bus.byteenable = 4'hf;
    reset = 1'b1;
`ifdef ONCHIP_MEM_ARB_STATS_EN
    stat_clear = 1'b0;
`endif
    m0_bus.read = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk) chk(m0_bus.waitrequest == 1'b0, "first_accept", m0_bus.waitrequest, 0);
    @(posedge clk) #1 m0_bus.read = 1'b0;
    xfer(0, 1, 14'h0010, 32'hDEADBEEF, 4'hf);
    xfer(0, 0, 14'h0010, 32'h0, 4'hf);
    @(negedge clk);
    chk(m0_bus.readdatavalid && m0_bus.readdata == 32'hDEADBEEF, "raw_m0", m0_bus.readdata, 32'hDEADBEEF);
    chk(!m1_bus.readdatavalid, "raw_m1_quiet", m1_bus.readdatavalid, 0);
    @(posedge clk) #1;
    xfer(1, 1, 14'h3FFF, 32'hAAAAAAAA, 4'hf);
    xfer(1, 1, 14'h3FFF, 32'h11223344, 4'h3);
    xfer(1, 0, 14'h3FFF, 32'h0, 4'hf);
    @(negedge clk) chk(m1_bus.readdatavalid && m1_bus.readdata == 32'hAAAA3344, "partial_wr", m1_bus.readdata, 32'hAAAA3344);
    @(posedge clk) #1;
`ifdef ONCHIP_MEM_ARB_STATS_EN
    stat_clear = 1'b1;
    @(posedge clk) #1 stat_clear = 1'b0;
`endif
    glog.delete();
    fork
      for (int i = 0; i < 12; i++) xfer(0, 0, 14'(i), 32'h0, 4'hf);
      begin
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 12; i++) xfer(1, 0, 14'(256 + i), 32'h0, 4'hf);
      end
    join
    chk(glog.size() == 24 && last_acc - first_acc == 23, "cont_no_bubble", glog.size(), 24);
    begin
      int bad;
      bad = 0;
      foreach (glog[i]) if (glog[i] != (i / MAX_HOLD) % 2) bad++;
      chk(bad == 0, "cont_order", bad, 0);
    end
`ifdef ONCHIP_MEM_ARB_STATS_EN
    chk(stat_m0_grants == 12 && stat_m1_grants == 12, "stat_grants", {stat_m1_grants, stat_m0_grants}, {32'd12, 32'd12});
    chk(stat_contention == 18, "stat_cont", stat_contention, 18);
    stat_clear = 1'b1;
    @(posedge clk) #1 stat_clear = 1'b0;
    chk(stat_m0_grants == 0 && stat_m1_grants == 0 && stat_contention == 0, "stat_clear",
        {stat_m0_grants, stat_m1_grants}, 0);
`endif
    xfer(1, 1, 14'h0005, 32'h12345678, 4'hf);
    xfer(0, 0, 14'h0005, 32'h0, 4'hf);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk(dut.owner == 1'b0 && dut.hold_cnt == 4'd0, "rst_state", {dut.owner, dut.hold_cnt}, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    fork
      repeat (40) begin
        int g;
        g = $urandom_range(0, 2);
        if (g > 0) begin repeat (g) @(posedge clk); #1; end
        xfer(0, 1'($urandom_range(0, 1)), 14'($urandom_range(0, 7)), $urandom, 4'($urandom_range(1, 15)));
      end
      repeat (40) begin
        int g;
        g = $urandom_range(0, 2);
        if (g > 0) begin repeat (g) @(posedge clk); #1; end
        xfer(1, 1'($urandom_range(0, 1)), 14'($urandom_range(0, 7)), $urandom, 4'($urandom_range(1, 15)));
      end
    join
    @(posedge clk) #1;
`ifdef ONCHIP_MEM_ARB_STATS_EN
    chk(stat_m0_grants == 32'(eg0) && stat_m1_grants == 32'(eg1), "stat_rand_grants",
        {stat_m1_grants, stat_m0_grants}, {32'(eg1), 32'(eg0)});
    chk(stat_contention == 32'(ec), "stat_rand_cont", stat_contention, ec);
`endif
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
